stateful_alu_4b: RTL and testbench

Single 4-byte ALU lane of an RMT action stage, sitting directly downstream of the action crossbar and consuming one lane of its `alu_in_4B_1/2/3` and per-container action outputs. Executes stateless arithmetic plus stateful load/store/load-add against a private register array. Results return in PHV container order to the PHV re-assembly logic. Two-cycle pipeline, one operation per cycle, with write-to-read forwarding so back-to-back stateful operations on the same address behave sequentially.

---
 rtl/rmt_alu_pkg.sv | 24 ++
 rtl/alu_state_ram.sv | 25 ++
 rtl/stateful_alu_4b.sv | 177 +++++++++++++++++
 tb/tb_stateful_alu_4b.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rmt_alu_pkg.sv
// Shared definitions for the RMT action-stage ALU lane.
// Opcodes, action field bounds and the lane FSM state type.
package rmt_alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SET   = 4'b1110;
  localparam logic [3:0] OP_STORE = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b0111;
  localparam logic [3:0] OP_LOADD = 4'b1011;

  localparam int OPC_HI = 24;
  localparam int OPC_LO = 21;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } alu_state_e;

endpackage

// File: rtl/alu_state_ram.sv
// Simple dual-port state array: one write, one read-first sync read.
// Ports: clk, we/waddr/wdata write port, raddr in, rdata out.
module alu_state_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // No reset so the array maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/stateful_alu_4b.sv
// One 4-byte RMT ALU lane: stateless math plus load/store/loadd.
// Ports: clk, rst_n, alu_in_valid, action_in, operand_1/2/3_in,
//        container_out, container_out_valid, init_done.
module stateful_alu_4b
  import rmt_alu_pkg::*;
#(
  parameter int STAGE_ID = 0,
  parameter int ACT_LEN  = 25,
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               alu_in_valid,
  input  logic [ACT_LEN-1:0] action_in,
  input  logic [WIDTH-1:0]   operand_1_in,
  input  logic [WIDTH-1:0]   operand_2_in,
  input  logic [WIDTH-1:0]   operand_3_in,
  output logic [WIDTH-1:0]   container_out,
  output logic               container_out_valid,
  output logic               init_done
);

  alu_state_e        state;
  alu_state_e        nstate;
  logic [ADDR_W-1:0] cnt;
  logic              init_wr;

  logic [3:0]        in_opc;
  logic [ADDR_W-1:0] in_addr;

  logic              s1_v;
  logic [3:0]        s1_opc;
  logic [ADDR_W-1:0] s1_addr;
  logic [WIDTH-1:0]  s1_op1;
  logic [WIDTH-1:0]  s1_op2;
  logic [WIDTH-1:0]  s1_op3;
  logic              s1_byp;
  logic [WIDTH-1:0]  s1_byp_d;

  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  mem_q;
  logic [WIDTH-1:0]  mem_inc;
  logic [WIDTH-1:0]  res;
  logic              st_wr;
  logic [WIDTH-1:0]  st_d;

  logic              is_add;
  logic              is_sub;
  logic              is_st;
  logic              is_ld;
  logic              is_ldd;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;

  logic              unused_bits;

  assign in_opc  = action_in[OPC_HI:OPC_LO];
  assign in_addr = operand_2_in[ADDR_W-1:0];

  assign unused_bits = ^{action_in[OPC_LO-1:0],
                         operand_2_in[WIDTH-1:ADDR_W],
                         (STAGE_ID != 0)};

  // FSM: state register and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= nstate;
      init_done <= (nstate == ST_RUN);
      if (state == ST_INIT) begin
        cnt <= cnt + ADDR_W'(1);
      end
    end
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    unique case (state)
      ST_INIT: if (cnt == '1) nstate = ST_RUN;
      ST_RUN:  nstate = ST_RUN;
      default: nstate = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    init_wr = (state == ST_INIT);
  end

  // Stage 1: capture operands, issue array read.
  // If stage 2 writes the address being read on this
  // edge, the array returns stale data, so latch the
  // write data as a bypass instead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_opc   <= '0;
      s1_addr  <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_op3   <= '0;
      s1_byp   <= 1'b0;
      s1_byp_d <= '0;
    end else begin
      s1_v     <= alu_in_valid & init_done;
      s1_opc   <= in_opc;
      s1_addr  <= in_addr;
      s1_op1   <= operand_1_in;
      s1_op2   <= operand_2_in;
      s1_op3   <= operand_3_in;
      s1_byp   <= st_wr && (s1_addr == in_addr);
      s1_byp_d <= st_d;
    end
  end

  alu_state_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (in_addr),
    .rdata (rd_data)
  );

  // Stage 2: decode and compute
  assign is_add = s1_opc inside {OP_ADD, OP_ADDI, OP_SET};
  assign is_sub = s1_opc inside {OP_SUB, OP_SUBI};
  assign is_st  = (s1_opc == OP_STORE);
  assign is_ld  = (s1_opc == OP_LOAD);
  assign is_ldd = (s1_opc == OP_LOADD);

  assign mem_q   = s1_byp ? s1_byp_d : rd_data;
  assign mem_inc = mem_q + WIDTH'(1);

  always_comb begin
    res = s1_op1;
    unique case (1'b1)
      is_add:  res = s1_op1 + s1_op2;
      is_sub:  res = s1_op1 - s1_op2;
      is_st:   res = s1_op3;
      is_ld:   res = mem_q;
      is_ldd:  res = mem_inc;
      default: res = s1_op1;
    endcase
  end

  assign st_wr = s1_v & (is_st | is_ldd);
  assign st_d  = is_st ? s1_op1 : mem_inc;

  // Clearing walk owns the write port during INIT.
  assign ram_we    = init_wr | st_wr;
  assign ram_waddr = init_wr ? cnt : s1_addr;
  assign ram_wdata = init_wr ? '0 : st_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      container_out       <= '0;
      container_out_valid <= 1'b0;
    end else begin
      container_out_valid <= s1_v;
      if (s1_v) begin
        container_out <= res;
      end
    end
  end

endmodule

// File: tb/tb_stateful_alu_4b.sv
// Self-checking bench for stateful_alu_4b.
// Sequential reference model plus literal spot checks.
module tb_stateful_alu_4b;
  import rmt_alu_pkg::*;

  localparam int D = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        alu_in_valid = 1'b0;
  logic [24:0] action_in = '0;
  logic [31:0] op1 = '0;
  logic [31:0] op2 = '0;
  logic [31:0] op3 = '0;
  logic [31:0] container_out;
  logic        container_out_valid;
  logic        init_done;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  bit          has_lit = 0;
  logic [31:0] lit_val = '0;

  always #5 clk = ~clk;

  stateful_alu_4b #(
    .STAGE_ID (0),
    .ACT_LEN  (25),
    .WIDTH    (32),
    .ADDR_W   (5)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alu_in_valid        (alu_in_valid),
    .action_in           (action_in),
    .operand_1_in        (op1),
    .operand_2_in        (op2),
    .operand_3_in        (op3),
    .container_out       (container_out),
    .container_out_valid (container_out_valid),
    .init_done           (init_done)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: sequential semantics, 2-cycle delay
  logic [31:0] m_mem [D];
  bit          m_ready;
  int          m_cnt;
  bit          m_s1_v, m_out_v, m_s1_l, m_out_l;
  logic [31:0] m_s1_d, m_out_d, m_s1_lv, m_out_lv;

  function automatic logic [31:0] model_op(
    input logic [3:0] opc,
    input logic [31:0] a, b, c);
    int ad;
    ad = int'(b[4:0]);
    case (opc)
      OP_ADD, OP_ADDI, OP_SET: return a + b;
      OP_SUB, OP_SUBI:         return a - b;
      OP_STORE: begin
        m_mem[ad] = a;
        return c;
      end
      OP_LOAD:  return m_mem[ad];
      OP_LOADD: begin
        m_mem[ad] = m_mem[ad] + 1;
        return m_mem[ad];
      end
      default:  return a;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m_mem[i] = '0;
      m_ready = 0;
      m_cnt   = 0;
      m_s1_v  = 0;
      m_out_v = 0;
      m_s1_l  = 0;
      m_out_l = 0;
      m_out_d = '0;
    end else begin
      m_out_v = m_s1_v;
      if (m_s1_v) m_out_d = m_s1_d;
      m_out_l  = m_s1_l & m_s1_v;
      m_out_lv = m_s1_lv;
      m_s1_v = alu_in_valid && m_ready;
      m_s1_l  = has_lit;
      m_s1_lv = lit_val;
      if (m_s1_v)
        m_s1_d = model_op(action_in[24:21], op1, op2, op3);
      if (!m_ready) begin
        m_cnt++;
        if (m_cnt == D) m_ready = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(container_out_valid), 32'(m_out_v));
      chk("init_done", 32'(init_done), 32'(m_ready));
      chk("out", container_out, m_out_d);
      if (m_out_v && m_out_l)
        chk("lit", container_out, m_out_lv);
    end
  end

  task automatic issue(input logic [3:0] opc,
                       input logic [31:0] a, b, c,
                       input bit hl,
                       input logic [31:0] lv);
    alu_in_valid = 1'b1;
    action_in    = {opc, 21'h0};
    op1 = a;
    op2 = b;
    op3 = c;
    has_lit = hl;
    lit_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    alu_in_valid = 1'b0;
    has_lit = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    while (!init_done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(n), 32'd32);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk_en = 1;
    #18;
    chk("rst_out", container_out, 32'h0);
    chk("rst_valid", 32'(container_out_valid), 32'h0);
    chk("rst_init", 32'(init_done), 32'h0);

    // Valid held high through INIT must be dropped
    @(negedge clk);
    #2;
    alu_in_valid = 1'b1;
    action_in    = {OP_LOADD, 21'h0};
    op2          = 32'd7;
    rst_n        = 1'b1;
    wait_init("init_lat");

    issue(OP_LOAD, 32'h0, 32'd7, 32'h0, 1, 32'h0);
    issue(OP_SUB, 32'h1, 32'h2, 32'h0, 1, 32'hFFFF_FFFF);
    issue(OP_ADD, 32'hFFFF_FFFF, 32'h2, 32'h0, 1, 32'h1);
    issue(OP_SET, 32'h0, 32'h55, 32'h0, 1, 32'h55);
    issue(OP_SUBI, 32'h10, 32'h3, 32'h0, 1, 32'hD);

    issue(OP_LOADD, 32'h0, 32'd3, 32'h0, 1, 32'd1);
    issue(OP_LOADD, 32'h0, 32'd3, 32'h0, 1, 32'd2);
    issue(OP_LOADD, 32'h0, 32'd3, 32'h0, 1, 32'd3);
    idle(2);
    issue(OP_LOAD, 32'h0, 32'd3, 32'h0, 1, 32'd3);

    issue(OP_STORE, 32'hDEAD_BEEF, 32'd5, 32'h1234,
          1, 32'h1234);
    issue(OP_LOAD, 32'h0, 32'd5, 32'h0, 1, 32'hDEAD_BEEF);

    issue(4'b0000, 32'hCAFE_F00D, 32'h9, 32'h1,
          1, 32'hCAFE_F00D);
    idle(4);
    chk("hold", container_out, 32'hCAFE_F00D);
    chk("hold_v", 32'(container_out_valid), 32'h0);

    // Reset while a loadd is in flight
    issue(OP_LOADD, 32'h0, 32'd1, 32'h0, 1, 32'd1);
    idle(2);
    issue(OP_LOADD, 32'h0, 32'd1, 32'h0, 0, 32'h0);
    alu_in_valid = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_init("reinit_lat");
    issue(OP_LOAD, 32'h0, 32'd1, 32'h0, 1, 32'h0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
